// File: rtl/ic_axi_pkg.sv
// Shared response codes, FSM encodings and op type for the AXI4-Lite to memory-bus bridge.
package ic_axi_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_REQ = 3'd1;
  localparam logic [2:0] ST_WR_REQ = 3'd2;
  localparam logic [2:0] ST_RD_RSP = 3'd3;
  localparam logic [2:0] ST_WR_RSP = 3'd4;
  localparam logic [2:0] ST_RD_OUT = 3'd5;
  localparam logic [2:0] ST_WR_OUT = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    RD_REQ = ST_RD_REQ,
    WR_REQ = ST_WR_REQ,
    RD_RSP = ST_RD_RSP,
    WR_RSP = ST_WR_RSP,
    RD_OUT = ST_RD_OUT,
    WR_OUT = ST_WR_OUT
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;
endpackage

// File: rtl/ic_axi_hold_reg.sv
// Single-entry holding register: data plus full flag. Loaded on an AXI handshake,
// emptied when the memory bus grants the op that consumes it.
module ic_axi_hold_reg #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_full
);
  logic [W-1:0] r_q;
  logic         r_full;

  // Load wins over clear; the two never coincide since load needs !full and clear needs full.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q    <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_q    <= i_d;
      r_full <= 1'b1;
    end else if (i_clr) begin
      r_full <= 1'b0;
    end
  end

  assign o_q    = r_q;
  assign o_full = r_full;
endmodule

// File: rtl/ic_axi_mem_bus_bridge.sv
// AXI4-Lite subordinate fronting a req/gnt + recv/ack memory bus. One memory op in flight;
// AW, W and AR each buffered in a single holding register while it runs.
module ic_axi_mem_bus_bridge
  import ic_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFFF
) (
  input  logic        s0_aclk,
  input  logic        s0_aresetn,
  input  logic        s0_awvalid,
  output logic        s0_awready,
  input  logic [31:0] s0_awaddr,
  input  logic [2:0]  s0_awprot,
  input  logic        s0_wvalid,
  output logic        s0_wready,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wstrb,
  output logic        s0_bvalid,
  input  logic        s0_bready,
  output logic [1:0]  s0_bresp,
  input  logic        s0_arvalid,
  output logic        s0_arready,
  input  logic [31:0] s0_araddr,
  input  logic [2:0]  s0_arprot,
  output logic        s0_rvalid,
  input  logic        s0_rready,
  output logic [1:0]  s0_rresp,
  output logic [31:0] s0_rdata,
  input  logic        enable,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_wen,
  output logic [3:0]  mem_strb,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic        mem_recv,
  output logic        mem_ack,
  input  logic        mem_error,
  input  logic [31:0] mem_rdata
);
  state_t      r_state, w_state_nxt;
  op_t         r_last_op, w_pick;
  logic        w_launch;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp, r_bresp;

  logic [31:0] w_aw_q, w_ar_q;
  logic [35:0] w_w_q;
  logic        w_aw_full, w_w_full, w_ar_full;
  logic        w_rd_pend, w_wr_pend;
  logic        w_unused;

  assign w_unused = ^{s0_awprot, s0_arprot};

  // Readies are held low while reset is asserted so nothing is accepted during it.
  assign s0_awready = !w_aw_full && s0_aresetn;
  assign s0_wready  = !w_w_full  && s0_aresetn;
  assign s0_arready = !w_ar_full && s0_aresetn;

  ic_axi_hold_reg #(.W(32)) u_aw (
    .i_clk(s0_aclk), .i_rst_n(s0_aresetn),
    .i_load(s0_awvalid && s0_awready), .i_clr((r_state == WR_REQ) && mem_gnt),
    .i_d(s0_awaddr), .o_q(w_aw_q), .o_full(w_aw_full)
  );

  ic_axi_hold_reg #(.W(36)) u_w (
    .i_clk(s0_aclk), .i_rst_n(s0_aresetn),
    .i_load(s0_wvalid && s0_wready), .i_clr((r_state == WR_REQ) && mem_gnt),
    .i_d({s0_wstrb, s0_wdata}), .o_q(w_w_q), .o_full(w_w_full)
  );

  ic_axi_hold_reg #(.W(32)) u_ar (
    .i_clk(s0_aclk), .i_rst_n(s0_aresetn),
    .i_load(s0_arvalid && s0_arready), .i_clr((r_state == RD_REQ) && mem_gnt),
    .i_d(s0_araddr), .o_q(w_ar_q), .o_full(w_ar_full)
  );

  assign w_wr_pend = w_aw_full && w_w_full;
  assign w_rd_pend = w_ar_full;

  // State register and arbitration history.
  always_ff @(posedge s0_aclk) begin
    if (!s0_aresetn) begin
      r_state   <= IDLE;
      r_last_op <= OP_WRITE;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) r_last_op <= w_pick;
    end
  end

  // Response capture; values hold until the next response so R/B stay stable while valid.
  always_ff @(posedge s0_aclk) begin
    if (!s0_aresetn) begin
      r_rdata <= '0;
      r_rresp <= AXI_RESP_OKAY;
      r_bresp <= AXI_RESP_OKAY;
    end else if (mem_recv && (r_state == RD_RSP)) begin
      r_rdata <= mem_rdata;
      r_rresp <= mem_error ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    end else if (mem_recv && (r_state == WR_RSP)) begin
      r_bresp <= mem_error ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    end
  end

  // Next-state, arbitration and bus outputs; a tie alternates against the last op issued.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_pick      = OP_READ;
    mem_req     = 1'b0;
    mem_wen     = 1'b0;
    mem_strb    = 4'b0000;
    mem_wdata   = 32'b0;
    mem_addr    = 32'b0;
    mem_ack     = 1'b0;
    s0_rvalid   = 1'b0;
    s0_bvalid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && (w_rd_pend || w_wr_pend)) begin
          w_launch = 1'b1;
          if (w_rd_pend && w_wr_pend) w_pick = (r_last_op == OP_WRITE) ? OP_READ : OP_WRITE;
          else                        w_pick = w_wr_pend ? OP_WRITE : OP_READ;
          w_state_nxt = (w_pick == OP_WRITE) ? WR_REQ : RD_REQ;
        end
      end
      RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = w_ar_q & ADDR_MASK;
        if (mem_gnt) w_state_nxt = RD_RSP;
      end
      WR_REQ: begin
        mem_req   = 1'b1;
        mem_wen   = 1'b1;
        mem_strb  = w_w_q[35:32];
        mem_wdata = w_w_q[31:0];
        mem_addr  = w_aw_q & ADDR_MASK;
        if (mem_gnt) w_state_nxt = WR_RSP;
      end
      RD_RSP: begin
        mem_ack = 1'b1;
        if (mem_recv) w_state_nxt = RD_OUT;
      end
      WR_RSP: begin
        mem_ack = 1'b1;
        if (mem_recv) w_state_nxt = WR_OUT;
      end
      RD_OUT: begin
        s0_rvalid = 1'b1;
        if (s0_rready) w_state_nxt = IDLE;
      end
      WR_OUT: begin
        s0_bvalid = 1'b1;
        if (s0_bready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign s0_rdata = r_rdata;
  assign s0_rresp = r_rresp;
  assign s0_bresp = r_bresp;
endmodule

// File: tb/tb_ic_axi_mem_bus_bridge.sv
// Bench for the AXI4-Lite to memory-bus bridge: directed scenarios plus a randomized phase,
// checked against per-channel transaction queues and an address-derived memory model.
module tb_ic_axi_mem_bus_bridge;
  localparam logic [31:0] MASK = 32'h00FF_FFFF;
  localparam int TMO = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s0_aresetn, s0_awvalid, s0_awready, s0_wvalid, s0_wready;
  logic        s0_bvalid, s0_bready, s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
  logic [2:0]  s0_awprot, s0_arprot;
  logic [3:0]  s0_wstrb;
  logic [1:0]  s0_bresp, s0_rresp;
  logic        enable, mem_req, mem_gnt, mem_wen, mem_recv, mem_ack, mem_error;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;

  ic_axi_mem_bus_bridge #(.ADDR_MASK(MASK)) dut (
    .s0_aclk(clk), .s0_aresetn(s0_aresetn),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr), .s0_awprot(s0_awprot),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bresp(s0_bresp),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr), .s0_arprot(s0_arprot),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rresp(s0_rresp), .s0_rdata(s0_rdata),
    .enable(enable), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_recv(mem_recv), .mem_ack(mem_ack),
    .mem_error(mem_error), .mem_rdata(mem_rdata)
  );

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // knobs for the memory-side responder and the R/B sinks
  int gnt_dly = 0, recv_dly = 0, err_mode = 0, r_hold_fix = 0, b_hold_fix = 0;
  bit fix_en = 0, abort = 0, rnd = 0;
  logic [31:0] fix_val = 32'h0;
  int t_ar = 0, rv_lat = 0;
  logic [31:0] lw_addr;
  logic [3:0]  lw_strb;

  // reference queues
  logic [31:0] rdq[$];
  logic [31:0] awq[$];
  logic [35:0] wq[$];
  logic [33:0] exp_r[$];
  logic [1:0]  exp_b[$];
  logic        op_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // memory model: error and read data are pure functions of the masked address
  function automatic logic err_of(input logic [31:0] a);
    if (err_mode == 0) return 1'b0;
    if (err_mode == 1) return 1'b1;
    return ^a[5:2];
  endfunction

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return fix_en ? fix_val : {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return err_of(a) ? 2'b10 : 2'b00;
  endfunction

  task automatic drv_ar(input logic [31:0] a);
    bit hs; int n;
    hs = 0; n = 0;
    s0_araddr = a; s0_arvalid = 1'b1;
    do begin
      #1; hs = s0_arready;
      if (hs) begin
        rdq.push_back(a & MASK);
        exp_r.push_back({resp_of(a & MASK), rd_of(a & MASK)});
        t_ar = cyc;
      end
      @(negedge clk); n++;
    end while (!hs && n < TMO);
    if (!hs) chk("ar_hs_timeout", 64'(hs), 64'd1);
    s0_arvalid = 1'b0;
  endtask

  task automatic drv_aw(input logic [31:0] a);
    bit hs; int n;
    hs = 0; n = 0;
    s0_awaddr = a; s0_awvalid = 1'b1;
    do begin
      #1; hs = s0_awready;
      if (hs) begin
        awq.push_back(a & MASK);
        exp_b.push_back(resp_of(a & MASK));
      end
      @(negedge clk); n++;
    end while (!hs && n < TMO);
    if (!hs) chk("aw_hs_timeout", 64'(hs), 64'd1);
    s0_awvalid = 1'b0;
  endtask

  task automatic drv_w(input logic [31:0] d, input logic [3:0] s);
    bit hs; int n;
    hs = 0; n = 0;
    s0_wdata = d; s0_wstrb = s; s0_wvalid = 1'b1;
    do begin
      #1; hs = s0_wready;
      if (hs) wq.push_back({s, d});
      @(negedge clk); n++;
    end while (!hs && n < TMO);
    if (!hs) chk("w_hs_timeout", 64'(hs), 64'd1);
    s0_wvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0 || rdq.size() != 0 ||
            awq.size() != 0 || wq.size() != 0) && n < TMO * 20) begin
      @(negedge clk); n++;
    end
    chk("drain_timeout", 64'(n < TMO * 20), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // memory-side responder: grants, checks the request against the AXI queues, returns data
  initial begin : mem_side
    logic [31:0] a, ea;
    logic [35:0] wd, ew;
    logic wen;
    int g, r;
    mem_gnt = 0; mem_recv = 0; mem_error = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        a = mem_addr; wen = mem_wen; wd = {mem_strb, mem_wdata};
        g = rnd ? int'($urandom_range(0, 3)) : gnt_dly;
        r = rnd ? int'($urandom_range(0, 3)) : recv_dly;
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          chk("req_hold_a", {mem_req, mem_wen, mem_addr}, {1'b1, wen, a});
          chk("req_hold_d", {mem_strb, mem_wdata}, wd);
        end
        mem_gnt = 1'b1;
        op_log.push_back(wen);
        if (wen) begin
          lw_addr = a; lw_strb = wd[35:32];
          chk("wr_queued", 64'(awq.size() != 0 && wq.size() != 0), 64'd1);
          if (awq.size() != 0 && wq.size() != 0) begin
            ea = awq.pop_front(); ew = wq.pop_front();
            chk("wr_addr", a, ea);
            chk("wr_data", wd, ew);
          end
        end else begin
          chk("rd_queued", 64'(rdq.size() != 0), 64'd1);
          if (rdq.size() != 0) begin
            ea = rdq.pop_front();
            chk("rd_addr", a, ea);
          end
          chk("rd_zero_data", wd, 64'd0);
        end
        @(negedge clk); mem_gnt = 1'b0;
        for (int k = 0; k < r && !abort; k++) @(negedge clk);
        if (abort) begin
          while (!s0_aresetn) @(negedge clk);
          mem_rdata = 32'h1BAD_F00D; mem_error = 1'b1; mem_recv = 1'b1;
          @(negedge clk); mem_recv = 1'b0; mem_error = 1'b0;
        end else begin
          chk("mem_ack", 64'(mem_ack), 64'd1);
          mem_rdata = wen ? $urandom : rd_of(a);
          mem_error = err_of(a);
          mem_recv  = 1'b1;
          @(negedge clk); mem_recv = 1'b0; mem_error = 1'b0;
        end
      end
    end
  end

  // R sink: optional hold-off with stability check, then compare against the expected queue
  initial begin : r_side
    logic [31:0] d; logic [1:0] rr; logic [33:0] e; int h;
    s0_rready = 0;
    forever begin
      @(negedge clk);
      if (s0_rvalid) begin
        rv_lat = cyc - t_ar;
        d = s0_rdata; rr = s0_rresp;
        h = (r_hold_fix >= 0) ? r_hold_fix : int'($urandom_range(0, 2));
        for (int k = 0; k < h; k++) begin
          @(negedge clk);
          chk("r_stable", {s0_rvalid, s0_rresp, s0_rdata}, {1'b1, rr, d});
        end
        s0_rready = 1'b1; @(negedge clk); s0_rready = 1'b0;
        chk("r_expected", 64'(exp_r.size() != 0), 64'd1);
        if (exp_r.size() != 0) begin
          e = exp_r.pop_front();
          chk("rresp", rr, e[33:32]);
          chk("rdata", d, e[31:0]);
        end
      end
    end
  end

  // B sink
  initial begin : b_side
    logic [1:0] br, e; int h;
    s0_bready = 0;
    forever begin
      @(negedge clk);
      if (s0_bvalid) begin
        br = s0_bresp;
        h = (b_hold_fix >= 0) ? b_hold_fix : int'($urandom_range(0, 2));
        for (int k = 0; k < h; k++) begin
          @(negedge clk);
          chk("b_stable", {s0_bvalid, s0_bresp}, {1'b1, br});
        end
        s0_bready = 1'b1; @(negedge clk); s0_bready = 1'b0;
        chk("b_expected", 64'(exp_b.size() != 0), 64'd1);
        if (exp_b.size() != 0) begin
          e = exp_b.pop_front();
          chk("bresp", br, e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

  initial begin : main
    int n;
    s0_aresetn = 0; enable = 1;
    s0_awvalid = 0; s0_wvalid = 0; s0_arvalid = 0;
    s0_awaddr = 0; s0_araddr = 0; s0_wdata = 0; s0_wstrb = 0;
    s0_awprot = 3'b010; s0_arprot = 3'b101;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_ready", {s0_awready, s0_wready, s0_arready}, 64'd0);
    chk("rst_valid", {s0_rvalid, s0_bvalid, mem_req, mem_ack}, 64'd0);
    chk("rst_resp", {s0_rresp, s0_bresp, s0_rdata}, 64'd0);
    chk("rst_mem", {mem_wen, mem_strb, mem_addr}, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    s0_aresetn = 1; @(negedge clk);
    chk("ready_after_rst", {s0_awready, s0_wready, s0_arready}, 64'd7);

    // 1: minimum-latency read with fixed data
    fix_en = 1; fix_val = 32'hDEAD_BEEF;
    drv_ar(32'h0000_0010);
    wait_idle();
    chk("t1_latency", rv_lat, 64'd4);
    chk("t1_rdata_held", s0_rdata, 64'hDEAD_BEEF);
    fix_en = 0;

    // 2: W two cycles ahead of AW
    fork
      drv_w(32'h1234_5678, 4'b0011);
      begin repeat (2) @(negedge clk); drv_aw(32'h0000_0020); end
    join
    wait_idle();
    chk("t2_addr", lw_addr, 64'h20);
    chk("t2_strb", lw_strb, 64'h3);

    // 3: read and write pending together straight from reset -> R, W, R, W
    s0_aresetn = 0; repeat (2) @(negedge clk); s0_aresetn = 1;
    op_log.delete(); r_hold_fix = -1; b_hold_fix = -1;
    fork
      begin drv_ar(32'h100); drv_ar(32'h104); end
      begin drv_aw(32'h200); drv_aw(32'h204); end
      begin drv_w(32'hAAAA_0001, 4'hF); drv_w(32'hBBBB_0002, 4'h5); end
    join
    wait_idle();
    chk("t3_count", op_log.size(), 64'd4);
    if (op_log.size() == 4)
      chk("t3_order", {op_log[0], op_log[1], op_log[2], op_log[3]}, 64'b0101);

    // 4: error responses, consumer holds ready low for 5 cycles
    err_mode = 1; r_hold_fix = 5; b_hold_fix = 5;
    drv_ar(32'h40);
    fork drv_aw(32'h44); drv_w(32'h0F0F_0F0F, 4'b1001); join
    wait_idle();
    err_mode = 0; r_hold_fix = 0; b_hold_fix = 0;

    // 5: slow grant; then enable low blocks issue
    gnt_dly = 4;
    fork drv_aw(32'h300); drv_w(32'hCAFE_F00D, 4'hF); join
    wait_idle();
    enable = 0;
    drv_ar(32'h50);
    for (int k = 0; k < 6; k++) begin
      chk("t5_no_req", 64'(mem_req), 64'd0);
      @(negedge clk);
    end
    enable = 1;
    wait_idle();
    gnt_dly = 0;

    // 6: reset while waiting for the read response
    recv_dly = 50;
    drv_ar(32'h60);
    n = 0;
    while (!mem_ack && n < TMO) begin @(negedge clk); n++; end
    chk("t6_reach_rsp", 64'(mem_ack), 64'd1);
    s0_aresetn = 0; abort = 1;
    @(negedge clk);
    chk("t6_rst_out", {s0_awready, s0_wready, s0_arready, s0_rvalid, s0_bvalid, mem_req, mem_ack}, 64'd0);
    chk("t6_rdata", s0_rdata, 64'd0);
    @(negedge clk);
    s0_aresetn = 1;
    exp_r.delete(); exp_b.delete(); rdq.delete();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t6_quiet", {s0_rvalid, mem_req, mem_ack}, 64'd0);
    end
    abort = 0; recv_dly = 0;
    drv_ar(32'h64);
    wait_idle();

    // randomized traffic with random bus timing, address-derived errors and enable gaps
    rnd = 1; err_mode = 2; r_hold_fix = -1; b_hold_fix = -1;
    fork
      for (int i = 0; i < 30; i++) begin repeat ($urandom_range(0, 3)) @(negedge clk); drv_ar($urandom); end
      for (int i = 0; i < 30; i++) begin repeat ($urandom_range(0, 3)) @(negedge clk); drv_aw($urandom); end
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        drv_w($urandom, 4'($urandom));
      end
      begin
        for (int i = 0; i < 150; i++) begin enable = ($urandom_range(0, 3) != 0); @(negedge clk); end
        enable = 1;
      end
    join
    enable = 1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
